position_read_controller: RTL
=============================

// Module: position_read_controller
// PURPOSE
//  Producer end of the compute-pipeline input interface. Walks every home cell of a periodic
//  CX*CY*CZ cell grid, reads reference and neighbor particles from the position RAM and drives
//  reference / neighbor / neighbor_cell in fixed 16-cycle windows, one neighbor slot per cycle.
//  Raises read_controller_done after the last window of the sweep.
// PARAMETERS
//  CX      3   cells along x (>=3)
//  CY      3   cells along y (>=3)
//  CZ      3   cells along z (>=3); CX*CY*CZ <= 256
//  ADDR_W  12  RAM address width = {cell[7:0], slot[3:0]}
// PORTS
//  clk                   in   1    single clock, all logic on posedge
//  reset                 in   1    synchronous, active-high
//  start                 in   1    1-cycle pulse, begins a sweep when idle
//  ref_raddr             out  12   reference RAM read address
//  ref_rdata             in   106  {id[8:0], valid, xyz[95:0]}, valid 1 cycle after ref_raddr
//  nbr_raddr             out  12   neighbor RAM read address
//  nbr_rdata             in   106  same format, valid 1 cycle after nbr_raddr
//  reference             out  114  {id[113:105], cell[104:97], valid[96], xyz[95:0]}
//  neighbor              out  106  {id[105:97], valid[96], xyz[95:0]}
//  neighbor_cell         out  8    cell index of current neighbor word
//  read_controller_done  out  1    sweep finished (level)
//  busy                  out  1    sweep in progress
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0. Reset mid-sweep aborts immediately; no resume.
//  - FSM: IDLE -(start)-> PRIME (1 cycle: issue ref_raddr for home 0 slot 0, nbr_raddr for
//    k=0 slot 0) -> STREAM -> DRAIN (1 cycle, last neighbor word leaves) -> DONE.
//    DONE -(start)-> PRIME with done cleared; start ignored in PRIME/STREAM/DRAIN.
//  - Loop order, outermost first: home cell h (0..N-1), reference slot r (0..15),
//    neighbor index k (0..13), neighbor slot s (0..15). One (h,r,k) per 16-cycle window.
//  - Cell id = x + CX*(y + CY*z). Neighbor cell k = home + offset[k], each axis mod C? (wrap).
//    offset[0..13] = (0,0,0),(1,0,0),(-1,1,0),(0,1,0),(1,1,0),(-1,-1,1),(0,-1,1),(1,-1,1),
//    (-1,0,1),(0,0,1),(1,0,1),(-1,1,1),(0,1,1),(1,1,1).
//  - nbr_raddr = {ncell, s}, issued one cycle before its word; neighbor <= nbr_rdata and
//    neighbor_cell <= ncell registered together, so word s of a window appears at window phase s.
//  - reference changes only at window boundaries whose (h,r) differs from the previous window;
//    stable for all 14*16 cycles of that reference. Next ref_raddr issued in the phase-14 cycle
//    of the last window of the current reference; reference <= {id, h, valid/xyz} at phase wrap.
//  - Empty slots (valid=0) are streamed unchanged; window timing never skips or stalls.
//  - busy=1 from PRIME through DRAIN. read_controller_done=1 from the cycle after DRAIN until
//    start or reset; reference/neighbor hold last values in DONE.
//  - Sweep length: N*16*14*16 output cycles + 1 prime + 1 drain (27 cells: 96768+2).
//  - All counters wrap exactly at bound (s:15->0 advances k; k:13->0 advances r; r:15->0 h).
// TESTING
//  T1 reset held 5 cycles with start=1 -> all outputs 0, busy=0, done=0 throughout.
//  T2 start, RAM word = {addr[8:0], 1, 96'(addr)} -> first window: reference cell 0 slot 0,
//     neighbor_cell=0, neighbor ids 0..15 on consecutive cycles; second window neighbor_cell=1.
//  T3 home (0,0,0), k=5 offset (-1,-1,1) -> neighbor_cell = 2+3*(2+3*1) = 17; k=2 -> 5.
//  T4 full 27-cell sweep -> done rises exactly 96770 cycles after start; reference changes
//     every 224 cycles; 432 distinct references; done stays high 100 cycles; start restarts.
//  T5 slot 7 of cell 4 valid=0 -> word passed with valid=0, window timing unchanged.
//  T6 reset asserted at cycle 5000 mid-sweep, start 3 cycles later -> sweep restarts at h=0,r=0.

Source files
------------

// File: rtl/position_read_controller.sv
// rtl/position_read_controller.sv - sweeps home cells and streams reference/neighbor words in 16-cycle windows
// Both RAMs have a one-cycle read latency; outputs are registered one cycle after the data returns.
module position_read_controller #(
  parameter int CX     = 3,
  parameter int CY     = 3,
  parameter int CZ     = 3,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] ref_raddr,
  input  logic [105:0]      ref_rdata,
  output logic [ADDR_W-1:0] nbr_raddr,
  input  logic [105:0]      nbr_rdata,
  output logic [113:0]      reference,
  output logic [105:0]      neighbor,
  output logic [7:0]        neighbor_cell,
  output logic              read_controller_done,
  output logic              busy
);

  localparam int N = CX * CY * CZ;
  localparam logic [7:0] CX_L = 8'(CX);
  localparam logic [7:0] CY_L = 8'(CY);
  localparam logic [7:0] CXM1 = 8'(CX - 1);
  localparam logic [7:0] CYM1 = 8'(CY - 1);
  localparam logic [7:0] CZM1 = 8'(CZ - 1);
  localparam logic [7:0] NM1  = 8'(N - 1);

  localparam logic [1:0] OZ = 2'b00;
  localparam logic [1:0] OP = 2'b01;
  localparam logic [1:0] OM = 2'b11;

  typedef enum logic [2:0] {IDLE, PRIME, STREAM, DRAIN, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  s_cnt, k_cnt, r_cnt;
  logic [7:0]  h_cnt, hx, hy, hz;
  logic        issued_all;
  logic        issue_en, last_issue, launch;
  logic [5:0]  oc;
  logic [7:0]  nx, ny, nz, ncell;
  logic [11:0] ref_next;
  logic        d1_valid, d1_first;
  logic [7:0]  d1_ncell, d1_h;

  // {dx, dy, dz}, each 2-bit: 00 = 0, 01 = +1, 11 = -1
  function automatic logic [5:0] offset_code(input logic [3:0] k);
    case (k)
      4'd1:    return {OP, OZ, OZ};
      4'd2:    return {OM, OP, OZ};
      4'd3:    return {OZ, OP, OZ};
      4'd4:    return {OP, OP, OZ};
      4'd5:    return {OM, OM, OP};
      4'd6:    return {OZ, OM, OP};
      4'd7:    return {OP, OM, OP};
      4'd8:    return {OM, OZ, OP};
      4'd9:    return {OZ, OZ, OP};
      4'd10:   return {OP, OZ, OP};
      4'd11:   return {OM, OP, OP};
      4'd12:   return {OZ, OP, OP};
      4'd13:   return {OP, OP, OP};
      default: return {OZ, OZ, OZ};
    endcase
  endfunction

  function automatic logic [7:0] wrap_step(input logic [7:0] v, input logic [1:0] d,
                                           input logic [7:0] last);
    case (d)
      OP:      return (v == last) ? 8'd0 : v + 8'd1;
      OM:      return (v == 8'd0) ? last : v - 8'd1;
      default: return v;
    endcase
  endfunction

  always_comb begin
    oc    = offset_code(k_cnt);
    nx    = wrap_step(hx, oc[5:4], CXM1);
    ny    = wrap_step(hy, oc[3:2], CYM1);
    nz    = wrap_step(hz, oc[1:0], CZM1);
    ncell = nx + CX_L * (ny + CY_L * nz);
  end

  assign issue_en   = (state == PRIME) || ((state == STREAM) && !issued_all);
  assign last_issue = (s_cnt == 4'd15) && (k_cnt == 4'd13) && (r_cnt == 4'd15) && (h_cnt == NM1);
  assign launch     = ((state == IDLE) || (state == DONE)) && start;
  assign ref_next   = (r_cnt == 4'd15) ? {((h_cnt == NM1) ? 8'd0 : h_cnt + 8'd1), 4'd0}
                                       : {h_cnt, r_cnt + 4'd1};

  assign nbr_raddr            = ADDR_W'({ncell, s_cnt});
  assign busy                 = (state == PRIME) || (state == STREAM) || (state == DRAIN);
  assign read_controller_done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = PRIME;
      PRIME:      state_nxt = STREAM;
      STREAM:     if (issued_all) state_nxt = DRAIN;
      DRAIN:      state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      s_cnt         <= '0;
      k_cnt         <= '0;
      r_cnt         <= '0;
      h_cnt         <= '0;
      hx            <= '0;
      hy            <= '0;
      hz            <= '0;
      issued_all    <= 1'b0;
      ref_raddr     <= '0;
      d1_valid      <= 1'b0;
      d1_first      <= 1'b0;
      d1_ncell      <= '0;
      d1_h          <= '0;
      reference     <= '0;
      neighbor      <= '0;
      neighbor_cell <= '0;
    end else begin
      state    <= state_nxt;
      d1_valid <= issue_en;
      d1_first <= issue_en && (k_cnt == 4'd0) && (s_cnt == 4'd0);
      d1_ncell <= ncell;
      d1_h     <= h_cnt;

      if (launch) begin
        s_cnt      <= '0;
        k_cnt      <= '0;
        r_cnt      <= '0;
        h_cnt      <= '0;
        hx         <= '0;
        hy         <= '0;
        hz         <= '0;
        issued_all <= 1'b0;
        ref_raddr  <= '0;
      end else if (issue_en) begin
        if (last_issue) issued_all <= 1'b1;
        // next reference is fetched two cycles before its first window so its data is ready
        if ((k_cnt == 4'd13) && (s_cnt == 4'd13)) ref_raddr <= ADDR_W'(ref_next);
        if (s_cnt == 4'd15) begin
          s_cnt <= '0;
          if (k_cnt == 4'd13) begin
            k_cnt <= '0;
            if (r_cnt == 4'd15) begin
              r_cnt <= '0;
              h_cnt <= (h_cnt == NM1) ? 8'd0 : h_cnt + 8'd1;
              if (hx == CXM1) begin
                hx <= '0;
                if (hy == CYM1) begin
                  hy <= '0;
                  hz <= (hz == CZM1) ? 8'd0 : hz + 8'd1;
                end else begin
                  hy <= hy + 8'd1;
                end
              end else begin
                hx <= hx + 8'd1;
              end
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end else begin
            k_cnt <= k_cnt + 4'd1;
          end
        end else begin
          s_cnt <= s_cnt + 4'd1;
        end
      end

      if (d1_valid) begin
        neighbor      <= nbr_rdata;
        neighbor_cell <= d1_ncell;
        if (d1_first) reference <= {ref_rdata[105:97], d1_h, ref_rdata[96:0]};
      end
    end
  end

endmodule
